// File: rtl/io_uart_port.sv
// io_uart_port: UART responder on the CPU I/O bus.
//   OUT to BASE_PORT+0 pushes a byte into the TX FIFO.
//   OUT to BASE_PORT+1 issues a command: b0 clears rx_valid, b1 clears overrun and ferr.
//   OUT to BASE_PORT+2 writes ctrl: b0 enables the rx irq, b1 enables the tx-empty irq.
//   IN reads rx_data, status {2'b0, ferr, overrun, rx_valid, tx_busy, fifo_empty, fifo_full}
//   or ctrl. Any other port reads 8'h00.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   port_id           I/O address from the CPU
//   out_port, io_strb write data and one-cycle write strobe
//   in_port           combinational read data
//   uart_rx, uart_tx  8N1 serial lines, both idle high
//   irq               one-cycle interrupt pulse
module io_uart_port #(
    parameter logic [7:0] BASE_PORT    = 8'h40,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       io_strb,
    output logic [7:0] in_port,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] PORT_DATA = BASE_PORT;
    localparam logic [7:0] PORT_STAT = BASE_PORT + 8'd1;
    localparam logic [7:0] PORT_CTRL = BASE_PORT + 8'd2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Bus decode
    logic wr_data, wr_cmd, wr_ctrl;
    assign wr_data = io_strb && (port_id == PORT_DATA);
    assign wr_cmd  = io_strb && (port_id == PORT_STAT);
    assign wr_ctrl = io_strb && (port_id == PORT_CTRL);

    // TX FIFO: pointers carry one extra wrap bit to tell full from empty
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, tx_pop, push_ok, tx_drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // TX state
    state_t        tx_st;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          tx_end, tx_busy;

    assign tx_end  = (tx_cnt == BIT_LAST);
    assign tx_busy = (tx_st != S_IDLE);
    assign tx_pop  = ((tx_st == S_IDLE) || ((tx_st == S_STOP) && tx_end)) && !fifo_empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands
    assign push_ok = wr_data && (!fifo_full || tx_pop);
    assign tx_drop = wr_data && fifo_full && !tx_pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= out_port;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tx_st   <= S_IDLE;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
            uart_tx <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            case (tx_st)
                S_IDLE: begin
                    if (tx_pop) begin
                        tx_sh   <= mem[rd_ptr[AW-1:0]];
                        tx_cnt  <= '0;
                        uart_tx <= 1'b0;
                        tx_st   <= S_START;
                    end
                end
                S_START: begin
                    if (tx_end) begin
                        tx_cnt  <= '0;
                        tx_bit  <= '0;
                        uart_tx <= tx_sh[0];
                        tx_st   <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            uart_tx <= 1'b1;
                            tx_st   <= S_STOP;
                        end else begin
                            tx_bit  <= tx_bit + 1'b1;
                            tx_sh   <= {1'b0, tx_sh[7:1]};
                            uart_tx <= tx_sh[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (tx_end) begin
                        tx_cnt <= '0;
                        // Chain straight into the next start bit when more data is queued
                        if (tx_pop) begin
                            tx_sh   <= mem[rd_ptr[AW-1:0]];
                            uart_tx <= 1'b0;
                            tx_st   <= S_START;
                        end else begin
                            tx_st <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // RX: 2-flop synchronizer, falling-edge start detect, mid-bit sampling
    logic [1:0]    rx_sync;
    logic          rx_s, rx_prev;
    state_t        rx_st;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_done;

    assign rx_s    = rx_sync[1];
    assign rx_done = (rx_st == S_STOP) && (rx_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
            rx_st   <= S_IDLE;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            rx_prev <= rx_s;
            case (rx_st)
                S_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_cnt <= '0;
                        rx_st  <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_st  <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        if (rx_bit == 3'd7) rx_st <= S_STOP;
                        else                rx_bit <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_done) begin
                        rx_cnt <= '0;
                        rx_st  <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Flags, control and interrupt
    logic [7:0] ctrl, rx_data;
    logic       rx_valid, overrun, ferr, cond, cond_q;

    assign cond = (ctrl[0] && rx_valid) || (ctrl[1] && fifo_empty && !tx_busy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl     <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            ferr     <= 1'b0;
            cond_q   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= out_port;
            if (wr_cmd && out_port[0]) rx_valid <= 1'b0;
            if (wr_cmd && out_port[1]) begin
                overrun <= 1'b0;
                ferr    <= 1'b0;
            end
            if (tx_drop) overrun <= 1'b1;
            // Placed after the command clears so a new byte wins on a shared edge
            if (rx_done) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
                ferr     <= !rx_s;
                if (rx_valid) overrun <= 1'b1;
            end
            cond_q <= cond;
            irq    <= cond && !cond_q;
        end
    end

    always_comb begin
        in_port = 8'h00;
        if (port_id == PORT_DATA)      in_port = rx_data;
        else if (port_id == PORT_STAT) in_port = {2'b00, ferr, overrun, rx_valid, tx_busy, fifo_empty, fifo_full};
        else if (port_id == PORT_CTRL) in_port = ctrl;
    end
endmodule

// File: tb/tb_io_uart_port.sv
// Directed testbench for io_uart_port with CLKS_PER_BIT=16.
module tb_io_uart_port;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       io_strb = 1'b0;
    logic [7:0] in_port;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic       irq;

    int checks = 0;
    int fails  = 0;
    int irq_cnt = 0;

    io_uart_port #(.BASE_PORT(8'h40), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
        .io_strb(io_strb), .in_port(in_port), .uart_rx(uart_rx),
        .uart_tx(uart_tx), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (irq) irq_cnt++;

    task automatic io_write(input logic [7:0] p, input logic [7:0] d);
        @(negedge clk);
        port_id = p; out_port = d; io_strb = 1'b1;
        @(negedge clk);
        io_strb = 1'b0; port_id = 8'h00;
    endtask

    task automatic rd(input logic [7:0] p, output logic [7:0] d);
        port_id = p;
        #1;
        d = in_port;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        logic [7:0] exp_rd [4] = '{8'h00, 8'h02, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            rd(8'h40 + 8'(i), v);
            checks++;
            if (v !== exp_rd[i]) begin
                fails++;
                $display("FAIL reset_read port=%0d got=%h exp=%h", i, v, exp_rd[i]);
            end
        end
        checks++;
        if (uart_tx !== 1'b1 || irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_pins got tx=%b irq=%b exp tx=1 irq=0", uart_tx, irq);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rd(8'h41, v);
        checks++;
        if (v !== 8'h02) begin fails++; $display("FAIL post_reset_status got=%h exp=02", v); end
    endtask

    task automatic test_decode();
        logic [7:0] v;
        io_write(8'h43, 8'hFF);
        io_write(8'h3F, 8'hFF);
        rd(8'h42, v);
        checks++;
        if (v !== 8'h00) begin fails++; $display("FAIL unmatched_write ctrl got=%h exp=00", v); end
        rd(8'h41, v);
        checks++;
        if (v !== 8'h02) begin fails++; $display("FAIL unmatched_write status got=%h exp=02", v); end
        io_write(8'h42, 8'hA5);
        rd(8'h42, v);
        checks++;
        if (v !== 8'hA5) begin fails++; $display("FAIL ctrl_write got=%h exp=a5", v); end
        rd(8'h43, v);
        checks++;
        if (v !== 8'h00) begin fails++; $display("FAIL other_port_read got=%h exp=00", v); end
        io_write(8'h42, 8'h00);
    endtask

    task automatic test_tx_single();
        logic [7:0] v;
        logic [9:0] frame = {1'b1, 8'h55, 1'b0};
        io_write(8'h40, 8'h55);
        checks++;
        if (uart_tx !== 1'b1) begin fails++; $display("FAIL tx_latency_idle got=%b exp=1", uart_tx); end
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0) begin fails++; $display("FAIL tx_start_edge got=%b exp=0", uart_tx); end
        repeat (8) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (uart_tx !== frame[k]) begin
                fails++;
                $display("FAIL tx_55_bit%0d got=%b exp=%b", k, uart_tx, frame[k]);
            end
            repeat (CPB) @(negedge clk);
        end
        rd(8'h41, v);
        checks++;
        if (v !== 8'h02) begin fails++; $display("FAIL tx_done_status got=%h exp=02", v); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        logic [9:0] got;
        logic [7:0] bytes [9] = '{8'hA5, 8'h3C, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h7E};
        @(negedge clk);
        port_id = 8'h40; io_strb = 1'b1;
        for (int i = 0; i < 9; i++) begin
            out_port = bytes[i];
            @(negedge clk);
        end
        io_strb = 1'b0;
        rd(8'h41, v);
        checks++;
        if (v !== 8'h05) begin fails++; $display("FAIL burst_status_full got=%h exp=05", v); end
        port_id = 8'h00;
        @(negedge clk);
        for (int f = 0; f < 9; f++) begin
            for (int k = 0; k < 10; k++) begin
                got[k] = uart_tx;
                repeat (CPB) @(negedge clk);
            end
            checks++;
            if (got !== {1'b1, bytes[f], 1'b0}) begin
                fails++;
                $display("FAIL burst_frame%0d got=%h exp=%h", f, got, {1'b1, bytes[f], 1'b0});
            end
        end
        repeat (20) @(negedge clk);
        rd(8'h41, v);
        checks++;
        if (v !== 8'h02) begin fails++; $display("FAIL burst_done_status got=%h exp=02", v); end
    endtask

    task automatic test_tx_overrun();
        logic [7:0] v;
        @(negedge clk);
        port_id = 8'h40; io_strb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            out_port = 8'(i + 1);
            @(negedge clk);
        end
        io_strb = 1'b0;
        rd(8'h41, v);
        checks++;
        if (v !== 8'h15) begin fails++; $display("FAIL tx_overrun_status got=%h exp=15", v); end
        port_id = 8'h00;
        repeat (9 * 10 * CPB + 30) @(negedge clk);
        rd(8'h41, v);
        checks++;
        if (v !== 8'h12) begin fails++; $display("FAIL tx_overrun_drained got=%h exp=12", v); end
        io_write(8'h41, 8'h02);
        rd(8'h41, v);
        checks++;
        if (v !== 8'h02) begin fails++; $display("FAIL tx_overrun_clear got=%h exp=02", v); end
    endtask

    task automatic test_rx();
        logic [7:0] v;
        send_rx(8'hA3, 1'b1);
        rd(8'h40, v);
        checks++;
        if (v !== 8'hA3) begin fails++; $display("FAIL rx_data got=%h exp=a3", v); end
        rd(8'h41, v);
        checks++;
        if (v !== 8'h0A) begin fails++; $display("FAIL rx_status got=%h exp=0a", v); end
        io_write(8'h41, 8'h01);
        rd(8'h41, v);
        checks++;
        if (v !== 8'h02) begin fails++; $display("FAIL rx_clear got=%h exp=02", v); end
    endtask

    task automatic test_rx_errors();
        logic [7:0] v;
        send_rx(8'hA3, 1'b1);
        send_rx(8'h3C, 1'b1);
        rd(8'h40, v);
        checks++;
        if (v !== 8'h3C) begin fails++; $display("FAIL rx_overwrite_data got=%h exp=3c", v); end
        rd(8'h41, v);
        checks++;
        if (v !== 8'h1A) begin fails++; $display("FAIL rx_overrun_status got=%h exp=1a", v); end
        send_rx(8'h5A, 1'b0);
        rd(8'h40, v);
        checks++;
        if (v !== 8'h5A) begin fails++; $display("FAIL rx_ferr_data got=%h exp=5a", v); end
        rd(8'h41, v);
        checks++;
        if (v !== 8'h3A) begin fails++; $display("FAIL rx_ferr_status got=%h exp=3a", v); end
        io_write(8'h41, 8'h02);
        rd(8'h41, v);
        checks++;
        if (v !== 8'h0A) begin fails++; $display("FAIL err_clear_status got=%h exp=0a", v); end
        io_write(8'h41, 8'h01);
        rd(8'h41, v);
        checks++;
        if (v !== 8'h02) begin fails++; $display("FAIL rx_clear2 got=%h exp=02", v); end
    endtask

    task automatic test_irq();
        logic [7:0] v;
        io_write(8'h42, 8'h01);
        irq_cnt = 0;
        send_rx(8'hC5, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (irq_cnt !== 1) begin fails++; $display("FAIL irq_rx_pulses got=%0d exp=1", irq_cnt); end
        io_write(8'h41, 8'h01);
        irq_cnt = 0;
        io_write(8'h42, 8'h02);
        repeat (30) @(negedge clk);
        checks++;
        if (irq_cnt !== 1) begin fails++; $display("FAIL irq_txempty_pulses got=%0d exp=1", irq_cnt); end
        rd(8'h42, v);
        checks++;
        if (v !== 8'h02) begin fails++; $display("FAIL irq_ctrl_read got=%h exp=02", v); end
        io_write(8'h42, 8'h00);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] v;
        io_write(8'h40, 8'h00);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0) begin fails++; $display("FAIL midframe_tx_low got=%b exp=0", uart_tx); end
        rst = 1'b1;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin fails++; $display("FAIL async_reset_tx got=%b exp=1", uart_tx); end
        rd(8'h41, v);
        checks++;
        if (v !== 8'h02) begin fails++; $display("FAIL async_reset_status got=%h exp=02", v); end
        rd(8'h40, v);
        checks++;
        if (v !== 8'h00) begin fails++; $display("FAIL async_reset_rxdata got=%h exp=00", v); end
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        rst = 1'b0;
        repeat (400) @(negedge clk);
        rd(8'h41, v);
        checks++;
        if (v !== 8'h02) begin fails++; $display("FAIL post_release_status got=%h exp=02", v); end
        checks++;
        if (uart_tx !== 1'b1) begin fails++; $display("FAIL post_release_tx got=%b exp=1", uart_tx); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_decode();
        test_tx_single();
        test_back_to_back();
        test_tx_overrun();
        test_rx();
        test_rx_errors();
        test_irq();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
